// File: rtl/infrared_tx_nec.sv
`timescale 1ns/1ps
// infrared_tx_nec: NEC-protocol IR transmitter.
// Serialises a full NEC frame (lead, 32 data bits LSB first, stop burst)
// or a repeat code, followed by an idle-high guard gap. ir_out is the
// baseband (low = burst), ir_led is the same burst on the IR carrier.
// Handshake: a request is taken on any clock edge where tx_start=1 and
// busy=0; busy then stays high until the edge that pulses done.
module infrared_tx_nec #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int CARRIER_FREQ = 38_000,
    parameter int GAP_US       = 40_000,
    // Protocol segment lengths in microseconds
    parameter int LEAD_L_US    = 9000,
    parameter int LEAD_H_US    = 4500,
    parameter int BIT_US       = 560,
    parameter int ONE_US       = 1680,
    parameter int RPT_US       = 2250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic       tx_repeat,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    output logic       ir_out,
    output logic       ir_led,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    localparam int US_CNT    = CLK_FREQ / 1_000_000;
    localparam int PRE_W     = (US_CNT > 1) ? $clog2(US_CNT) : 1;
    localparam int HALF      = CLK_FREQ / (2 * CARRIER_FREQ);
    localparam int CAR_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SEG_MAX_A = (LEAD_L_US > GAP_US) ? LEAD_L_US : GAP_US;
    localparam int SEG_MAX_B = (ONE_US > RPT_US) ? ONE_US : RPT_US;
    localparam int SEG_MAX_C = (SEG_MAX_A > SEG_MAX_B) ? SEG_MAX_A : SEG_MAX_B;
    localparam int SEG_MAX   = (SEG_MAX_C > LEAD_H_US) ? SEG_MAX_C : LEAD_H_US;
    localparam int SEG_W     = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD_L = 3'd1,
        S_LEAD_H = 3'd2,
        S_BIT_L  = 3'd3,
        S_BIT_H  = 3'd4,
        S_RPT_H  = 3'd5,
        S_STOP_L = 3'd6,
        S_GAP    = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PRE_W-1:0]   r_pre;
    logic [SEG_W-1:0]   r_seg;
    logic [SEG_W-1:0]   w_seg_last;
    logic [4:0]         r_idx;
    logic [31:0]        r_shift;
    logic               r_rpt;
    logic               r_ir_out;
    logic               r_led;
    logic               r_busy;
    logic               r_done;
    logic [CAR_W-1:0]   r_car;
    logic               r_carrier;
    logic [CAR_W-1:0]   w_car_next;
    logic               w_carrier_next;
    logic               w_led_next;
    logic               w_tick;
    logic               w_seg_end;
    logic               w_accept;
    logic               w_next_low;
    logic               w_cur_low;

    assign w_tick    = (r_pre == PRE_W'(US_CNT - 1));
    assign w_accept  = (r_state == S_IDLE) && tx_start && !r_busy;
    assign w_seg_end = (r_state != S_IDLE) && w_tick && (r_seg == w_seg_last);
    assign w_cur_low = (r_state == S_LEAD_L) || (r_state == S_BIT_L) || (r_state == S_STOP_L);

    // Last microsecond index of the current segment (duration minus one)
    always_comb begin
        w_seg_last = '0;
        case (r_state)
            S_LEAD_L: w_seg_last = SEG_W'(LEAD_L_US - 1);
            S_LEAD_H: w_seg_last = SEG_W'(LEAD_H_US - 1);
            S_BIT_L:  w_seg_last = SEG_W'(BIT_US - 1);
            S_BIT_H:  w_seg_last = r_shift[0] ? SEG_W'(ONE_US - 1) : SEG_W'(BIT_US - 1);
            S_RPT_H:  w_seg_last = SEG_W'(RPT_US - 1);
            S_STOP_L: w_seg_last = SEG_W'(BIT_US - 1);
            S_GAP:    w_seg_last = SEG_W'(GAP_US - 1);
            default:  w_seg_last = '0;
        endcase
    end

    // FSM next state plus next values of the carrier and registered outputs
    always_comb begin
        w_next_state   = r_state;
        w_car_next     = '0;
        w_carrier_next = 1'b1;
        case (r_state)
            S_IDLE:   if (w_accept)  w_next_state = S_LEAD_L;
            S_LEAD_L: if (w_seg_end) w_next_state = r_rpt ? S_RPT_H : S_LEAD_H;
            S_LEAD_H: if (w_seg_end) w_next_state = S_BIT_L;
            S_BIT_L:  if (w_seg_end) w_next_state = S_BIT_H;
            S_BIT_H:  if (w_seg_end) w_next_state = (r_idx == 5'd31) ? S_STOP_L : S_BIT_L;
            S_RPT_H:  if (w_seg_end) w_next_state = S_STOP_L;
            S_STOP_L: if (w_seg_end) w_next_state = S_GAP;
            S_GAP:    if (w_seg_end) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
        w_next_low = (w_next_state == S_LEAD_L) || (w_next_state == S_BIT_L) ||
                     (w_next_state == S_STOP_L);
        // The carrier restarts high on entry to every burst and only runs inside one
        if (w_next_low && w_cur_low) begin
            if (r_car == CAR_W'(HALF - 1)) begin
                w_car_next     = '0;
                w_carrier_next = ~r_carrier;
            end else begin
                w_car_next     = r_car + 1'b1;
                w_carrier_next = r_carrier;
            end
        end
        w_led_next = w_next_low & w_carrier_next;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Time base (prescaler, segment counter) and bit shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_seg   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_rpt   <= 1'b0;
        end else if (w_accept) begin
            r_pre   <= '0;
            r_seg   <= '0;
            r_idx   <= '0;
            r_shift <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
            r_rpt   <= tx_repeat;
        end else if (r_state != S_IDLE) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_seg_end)   r_seg <= '0;
            else if (w_tick) r_seg <= r_seg + 1'b1;
            if (w_seg_end && (r_state == S_BIT_H)) begin
                r_shift <= r_shift >> 1;
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    // Registered outputs and carrier generator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_out  <= 1'b1;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_car     <= '0;
            r_carrier <= 1'b0;
        end else begin
            r_ir_out  <= ~w_next_low;
            r_led     <= w_led_next;
            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= (r_state == S_GAP) && w_seg_end;
            r_car     <= w_car_next;
            r_carrier <= w_carrier_next;
        end
    end

    assign ir_out    = r_ir_out;
    assign ir_led    = r_led;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_infrared_tx_nec.sv
`timescale 1ns/1ps
// Bench for infrared_tx_nec: a scaled-timing instance for whole frames and a
// default-parameter instance for reset values and the 657-clock carrier.
module tb_infrared_tx_nec;

    // Scaled timing of the main instance: 4 clocks per us, carrier half-period 4
    localparam int US   = 4;
    localparam int HALF = 4;
    localparam int GAP  = 10;
    localparam int LL   = 18;
    localparam int LH   = 9;
    localparam int BT   = 2;
    localparam int ONE  = 6;
    localparam int RPT  = 5;
    // (18 + 9 + 16*(2+2) + 16*(2+6) + 2 + 10) * 4
    localparam int FRAME_CLKS  = 924;
    // (18 + 5 + 2 + 10) * 4
    localparam int REPEAT_CLKS = 140;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0, tx_repeat = 1'b0;
    logic [7:0] tx_addr = 8'h00, tx_cmd = 8'h00;
    logic       ir_out, ir_led, busy, done;
    logic [2:0] dbg_state;

    logic       rst_n_d = 1'b0;
    logic       tx_start_d = 1'b0;
    logic       ir_out_d, ir_led_d, busy_d, done_d;
    logic [2:0] dbg_state_d;

    infrared_tx_nec #(
        .CLK_FREQ(4_000_000), .CARRIER_FREQ(500_000), .GAP_US(GAP),
        .LEAD_L_US(LL), .LEAD_H_US(LH), .BIT_US(BT), .ONE_US(ONE), .RPT_US(RPT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_repeat(tx_repeat),
        .tx_addr(tx_addr), .tx_cmd(tx_cmd), .ir_out(ir_out), .ir_led(ir_led),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    infrared_tx_nec dut_def (
        .clk(clk), .rst_n(rst_n_d), .tx_start(tx_start_d), .tx_repeat(1'b0),
        .tx_addr(8'h12), .tx_cmd(8'h34), .ir_out(ir_out_d), .ir_led(ir_led_d),
        .busy(busy_d), .done(done_d), .dbg_state(dbg_state_d)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    int   cyc = 0;
    int   edge_q[$];
    logic prev_ir = 1'b1;
    logic prev_busy = 1'b0;
    logic exp_led;
    int   fall_cyc = 0;
    int   busy_rise = -1, busy_fall = -1;
    int   done_cnt = 0, done_cyc = -1;
    int   led_err = 0;

    always @(negedge clk) begin
        cyc++;
        if (ir_out === 1'b0) begin
            if (prev_ir !== 1'b0) fall_cyc = cyc;
            exp_led = (((cyc - fall_cyc) / HALF) % 2) == 0;
        end else begin
            exp_led = 1'b0;
        end
        if (ir_led !== exp_led) led_err++;
        if (ir_out !== prev_ir) edge_q.push_back(cyc);
        prev_ir = ir_out;
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise = cyc;
        if (busy === 1'b0 && prev_busy === 1'b1) busy_fall = cyc;
        prev_busy = busy;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        edge_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        led_err   = 0;
        busy_rise = -1;
        busy_fall = -1;
    endtask

    task automatic start_tx(input logic [7:0] a, input logic [7:0] c, input logic rpt,
                            input string tag);
        @(negedge clk);
        tx_addr   = a;
        tx_cmd    = c;
        tx_repeat = rpt;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        tx_addr   = 8'($urandom_range(0, 255));
        tx_cmd    = 8'($urandom_range(0, 255));
        tx_repeat = ~rpt;
        chk({tag, " accept ir_out"}, 32'(ir_out), 32'd0);
        chk({tag, " accept busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " finished in time"}, 32'(n < max), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input logic [7:0] a, input logic [7:0] c, input string tag);
        logic [31:0] w, d;
        int got, sp;
        w = {~c, c, ~a, a};
        exp_q.delete();
        exp_q.push_back(LL * US);
        exp_q.push_back(LH * US);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(BT * US);
            exp_q.push_back((w[i] ? ONE : BT) * US);
        end
        exp_q.push_back(BT * US);
        chk({tag, " edge count"}, edge_q.size(), exp_q.size() + 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i + 1 < edge_q.size()) ? edge_q[i+1] - edge_q[i] : -1;
            chk($sformatf("%s seg%0d", tag, i), got, exp_q[i]);
        end
        d = '0;
        for (int i = 0; i < 32; i++) begin
            sp = (4 + 2*i < edge_q.size()) ? edge_q[4+2*i] - edge_q[3+2*i] : 0;
            d[i] = (sp > ((BT + ONE) * US) / 2);
        end
        chk({tag, " decoded data"}, {16'h0, d[7:0], d[23:16]}, {16'h0, a, c});
        chk({tag, " inverse bytes"}, 32'((d[15:8] == ~d[7:0]) && (d[31:24] == ~d[23:16])), 32'd1);
        chk({tag, " busy clocks"}, busy_fall - busy_rise, FRAME_CLKS);
        chk({tag, " done count"}, done_cnt, 1);
        chk({tag, " done with busy fall"}, done_cyc, busy_fall);
        chk({tag, " carrier errors"}, led_err, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;

        // Reset values on both instances
        repeat (3) @(negedge clk);
        chk("rst ir_out", 32'(ir_out), 32'd1);
        chk("rst ir_led", 32'(ir_led), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst state", 32'(dbg_state), 32'd0);
        chk("def rst ir_out", 32'(ir_out_d), 32'd1);

        // Default-parameter carrier: 657 clocks high, 657 low, in the lead burst
        rst_n_d = 1'b1;
        @(negedge clk);
        tx_start_d = 1'b1;
        @(negedge clk);
        tx_start_d = 1'b0;
        chk("def lead ir_out", 32'(ir_out_d), 32'd0);
        chk("def busy", 32'(busy_d), 32'd1);
        n = 0;
        while (ir_led_d === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("def carrier high run", n, 657);
        n = 0;
        while (ir_led_d === 1'b0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("def carrier low run", n, 657);
        chk("def still lead low", 32'(ir_out_d), 32'd0);
        rst_n_d = 1'b0;
        #1;
        chk("def async rst ir_out", 32'(ir_out_d), 32'd1);
        chk("def async rst ir_led", 32'(ir_led_d), 32'd0);

        // Frame 0x12/0x34 with an ignored request mid-frame
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        start_tx(8'h12, 8'h34, 1'b0, "frame1234");
        repeat (300) @(negedge clk);
        tx_addr  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("ignore busy held", 32'(busy), 32'd1);
        wait_idle(2000, "frame1234");
        check_frame(8'h12, 8'h34, "frame1234");

        // Single repeat code
        clear_mon();
        start_tx(8'h00, 8'h00, 1'b1, "repeat");
        wait_idle(500, "repeat");
        chk("repeat edge count", edge_q.size(), 4);
        chk("repeat lead low", (edge_q.size() > 1) ? edge_q[1] - edge_q[0] : -1, LL * US);
        chk("repeat space", (edge_q.size() > 2) ? edge_q[2] - edge_q[1] : -1, RPT * US);
        chk("repeat stop low", (edge_q.size() > 3) ? edge_q[3] - edge_q[2] : -1, BT * US);
        chk("repeat busy clocks", busy_fall - busy_rise, REPEAT_CLKS);
        chk("repeat done count", done_cnt, 1);
        chk("repeat carrier errors", led_err, 0);

        // tx_start held: second repeat is accepted on the edge after done
        clear_mon();
        @(negedge clk);
        tx_repeat = 1'b1;
        tx_start  = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("held done seen", 32'(n < 500), 32'd1);
        chk("held busy low with done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("held reaccept busy", 32'(busy), 32'd1);
        chk("held reaccept ir_out", 32'(ir_out), 32'd0);
        chk("held reaccept done gone", 32'(done), 32'd0);
        tx_start = 1'b0;
        wait_idle(500, "held");
        chk("held done count", done_cnt, 2);
        chk("held gap to next lead", (edge_q.size() > 4) ? edge_q[4] - edge_q[3] : -1, GAP * US + 1);
        chk("held edge count", edge_q.size(), 8);

        // Reset in the space of bit 10
        clear_mon();
        start_tx(8'h12, 8'h34, 1'b0, "rstframe");
        n = 0;
        while (edge_q.size() < 24 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rstframe reached bit10", 32'(n < 2000), 32'd1);
        repeat (2) @(negedge clk);
        chk("rstframe in bit space", 32'(dbg_state), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("midrst ir_out", 32'(ir_out), 32'd1);
        chk("midrst ir_led", 32'(ir_led), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst state", 32'(dbg_state), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst no done", done_cnt, 0);

        // Fresh frame after reset
        clear_mon();
        start_tx(8'hA5, 8'h5A, 1'b0, "frameA55A");
        wait_idle(2000, "frameA55A");
        check_frame(8'hA5, 8'h5A, "frameA55A");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop so a stuck run still ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
